// File: rtl/mem_resp32_if.sv
// mem_resp32_if: request/response channel between an initiator (master) and the mem_resp32 responder (slave).
interface mem_resp32_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/mem_resp32.sv
// mem_resp32: word memory responder with fixed response latency and an in-order response FIFO.
// Build macro MEM_RESP32_ALIGN_CHECK_EN adds misaligned-address and empty-byte-enable write errors.
module mem_resp32 #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 4
) (
    input logic         clk,
    input logic         reset,
    mem_resp32_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int SL = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [CW-1:0] MAX_COUNT = CW'(OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR  = PW'(OUTSTANDING - 1);

    typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;

    state_t        state, next_state;
    logic [CW-1:0] count, count_next;
    logic          armed;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          align_err, req_err, accept, transfer;
    logic [31:0]   in_data;

    logic [SL-1:0] sr_valid, sr_err;
    logic [31:0]   sr_data [SL];

    logic          push_valid, push_err;
    logic [31:0]   push_data;

    logic [31:0]            fifo_data [OUTSTANDING];
    logic [OUTSTANDING-1:0] fifo_err;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          fifo_cnt;

`ifdef MEM_RESP32_ALIGN_CHECK_EN
    assign align_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_we && bus.req_be == 4'b0000);
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.req_addr[1:0];
    assign align_err = 1'b0;
`endif

    assign idx      = bus.req_addr[AW+1:2];
    assign req_err  = (|bus.req_addr[31:AW+2]) || align_err;
    assign accept   = bus.req_valid && bus.req_ready && !reset;
    assign transfer = bus.rsp_valid && bus.rsp_ready;
    assign in_data  = (bus.req_we || req_err) ? '0 : mem[idx];

    // Array has no reset so its contents survive a reset of the control path.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.req_be[b]) mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_valid <= '0;
            sr_err   <= '0;
        end else begin
            sr_valid[0] <= accept;
            sr_err[0]   <= req_err;
            sr_data[0]  <= in_data;
            for (int i = 1; i < SL; i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_err[i]   <= sr_err[i-1];
                sr_data[i]  <= sr_data[i-1];
            end
        end
    end

    // Entries reach the FIFO LATENCY-1 edges after acceptance, so an idle channel answers in LATENCY cycles.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_valid = accept;
            assign push_err   = req_err;
            assign push_data  = in_data;
        end else begin : g_piped
            assign push_valid = sr_valid[SL-1];
            assign push_err   = sr_err[SL-1];
            assign push_data  = sr_data[SL-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_valid) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_err[wr_ptr]  <= push_err;
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (transfer) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            case ({push_valid, transfer})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            armed <= 1'b0;
        end else begin
            state <= next_state;
            count <= count_next;
            armed <= 1'b1;
        end
    end

    always_comb begin
        count_next = count;
        next_state = state;
        if (accept && !transfer)      count_next = count + CW'(1);
        else if (!accept && transfer) count_next = count - CW'(1);
        if (count_next == '0)             next_state = IDLE;
        else if (count_next == MAX_COUNT) next_state = FULL;
        else                              next_state = BUSY;
    end

    assign bus.req_ready = armed && (state != FULL);
    assign bus.rsp_valid = (fifo_cnt != '0);
    assign bus.rsp_data  = bus.rsp_valid ? fifo_data[rd_ptr] : '0;
    assign bus.rsp_err   = bus.rsp_valid && fifo_err[rd_ptr];

endmodule

// File: tb/tb_mem_resp32.sv
// tb_mem_resp32: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mem_resp32;
    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;
    localparam int OUTSTANDING = 4;
    localparam int AW          = $clog2(DEPTH_WORDS);

    typedef struct {
        logic [31:0] data;
        bit          err;
        bit          known;
        int          t;
    } resp_t;

    logic clk;
    logic reset;
    mem_resp32_if bus();

    mem_resp32 #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY(LATENCY),
        .OUTSTANDING(OUTSTANDING)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [31:0] ref_mem   [DEPTH_WORDS];
    logic [3:0]  ref_known [DEPTH_WORDS];
    resp_t       exp_q[$];
    int          edge_n;
    bit          started, rst_seen, exp_valid, exp_ready;
    int          total_checks, bad_checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at edge %0d", tag, observed, expected, edge_n);
        end
    endtask

    // Reference behaviour of one accepted request; writes land in the model array immediately.
    function automatic resp_t modelRequest(input logic [31:0] addr, input logic [31:0] wdata,
                                           input bit we, input logic [3:0] be, input int t);
        resp_t r;
        r.t     = t;
        r.data  = 32'd0;
        r.known = 1'b1;
        r.err   = (addr >= 32'(DEPTH_WORDS * 4));
`ifdef MEM_RESP32_ALIGN_CHECK_EN
        if (addr[1:0] != 2'b00 || (we && be == 4'b0000)) r.err = 1'b1;
`endif
        if (!r.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        ref_mem[addr[AW+1:2]][8*b +: 8] = wdata[8*b +: 8];
                        ref_known[addr[AW+1:2]][b] = 1'b1;
                    end
                end
            end else begin
                r.data  = ref_mem[addr[AW+1:2]];
                r.known = (ref_known[addr[AW+1:2]] == 4'hF);
            end
        end
        return r;
    endfunction

    // At each falling edge: check outputs for this cycle, then predict the next rising edge.
    always @(negedge clk) begin
        if (started) begin
            exp_ready = !rst_seen && (exp_q.size() < OUTSTANDING);
            exp_valid = (exp_q.size() > 0) && (edge_n >= exp_q[0].t + LATENCY - 1);
            checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
            if (exp_valid && bus.rsp_valid) begin
                if (exp_q[0].known) checkOutput("rsp_data", bus.rsp_data, exp_q[0].data);
                checkOutput("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
            end
            if (rst_seen) begin
                checkOutput("rst_rsp_data", bus.rsp_data, 32'd0);
                checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
            end
        end else begin
            exp_ready = 1'b0;
            exp_valid = 1'b0;
        end
        if (reset) begin
            exp_q.delete();
            rst_seen = 1'b1;
            started  = 1'b1;
        end else begin
            rst_seen = 1'b0;
            if (started) begin
                if (exp_valid && bus.rsp_ready) void'(exp_q.pop_front());
                if (bus.req_valid && exp_ready)
                    exp_q.push_back(modelRequest(bus.req_addr, bus.req_wdata, bus.req_we, bus.req_be, edge_n + 1));
            end
        end
        edge_n++;
    end

    task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [31:0] wd, input bit we,
                                 input logic [3:0] be, input bit rr, output bit acc);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_we    = we;
        bus.req_be    = be;
        bus.rsp_ready = rr;
        @(negedge clk);
        acc = v && bus.req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic sendReq(input logic [31:0] a, input logic [31:0] wd, input bit we,
                           input logic [3:0] be, input bit rr);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 100) begin
            applyStimulus(1'b1, a, wd, we, be, rr, acc);
            n++;
        end
        bus.req_valid = 1'b0;
        if (!acc) checkOutput("req_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idleCycles(input int n, input bit rr);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 4'h0, rr, acc);
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b1, acc);
            n++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b1, acc);
    endtask

    function automatic logic [31:0] randAddr();
        int unsigned k = $urandom_range(0, 9);
        logic [31:0] a;
        if (k == 0)      a = 32'(DEPTH_WORDS * 4) + 32'($urandom_range(0, 255));
        else if (k == 1) a = $urandom | 32'h8000_0000;
        else if (k == 2) a = 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(1, 3));
        else             a = 32'($urandom_range(0, 63) * 4);
        return a;
    endfunction

    initial begin
        bit          acc, v, we, rr;
        int          accepted, waited;
        logic [31:0] a, wd;
        logic [3:0]  be;

        for (int i = 0; i < DEPTH_WORDS; i++) ref_known[i] = 4'h0;
        edge_n = 0; started = 1'b0; rst_seen = 1'b0;
        total_checks = 0; bad_checks = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_we = 1'b0; bus.req_be = '0; bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idleCycles(2, 1'b1);

        for (int i = 0; i < 64; i++) sendReq(32'(i * 4), $urandom, 1'b1, 4'hF, 1'b1);
        drain();

        // Idle-channel latency of a write then a read to the same word.
        sendReq(32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 1'b1);
        sendReq(32'h10, 32'd0, 1'b0, 4'h0, 1'b1);
        drain();

        sendReq(32'h20, 32'h11223344, 1'b1, 4'hF, 1'b1);
        sendReq(32'h20, 32'hAABBCCDD, 1'b1, 4'h5, 1'b1);
        sendReq(32'h20, 32'd0, 1'b0, 4'h0, 1'b1);
        drain();
        checkOutput("be_merge_model", ref_mem[8], 32'h11BB33DD);

        // Six reads offered against a stalled response channel.
        accepted = 0;
        for (int i = 0; i < 10 && accepted < 6; i++) begin
            applyStimulus(1'b1, 32'(64 + 4 * accepted), 32'd0, 1'b0, 4'h0, 1'b0, acc);
            if (acc) accepted++;
        end
        bus.req_valid = 1'b0;
        checkOutput("bp_accepted", 32'(accepted), 32'd4);
        idleCycles(3, 1'b0);
        drain();

        // Full channel: a response leaves in the same cycle a new request waits.
        for (int i = 0; i < 4; i++) sendReq(32'(128 + 4 * i), 32'd0, 1'b0, 4'h0, 1'b0);
        idleCycles(3, 1'b0);
        waited = 0;
        acc = 1'b0;
        for (int i = 0; i < 5 && !acc; i++) begin
            applyStimulus(1'b1, 32'h30, 32'd0, 1'b0, 4'h0, 1'b1, acc);
            if (!acc) waited++;
        end
        bus.req_valid = 1'b0;
        checkOutput("simul_wait", 32'(waited), 32'd1);
        drain();

        sendReq(32'h13, 32'd0, 1'b0, 4'h0, 1'b1);
        sendReq(32'(DEPTH_WORDS * 4), 32'hCAFEF00D, 1'b1, 4'hF, 1'b1);
        sendReq(32'h0, 32'd0, 1'b0, 4'h0, 1'b1);
        drain();

        // Reset with three responses still pending.
        sendReq(32'h40, 32'h5A5AA5A5, 1'b1, 4'hF, 1'b1);
        drain();
        for (int i = 0; i < 3; i++) sendReq(32'(4 * i), 32'd0, 1'b0, 4'h0, 1'b0);
        idleCycles(2, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
        sendReq(32'h40, 32'd0, 1'b0, 4'h0, 1'b1);
        drain();

        for (int c = 0; c < 1500; c++) begin
            v  = ($urandom_range(0, 9) < 6);
            we = $urandom_range(0, 1) == 1;
            be = 4'($urandom);
            a  = randAddr();
            wd = $urandom;
            rr = ($urandom_range(0, 9) < 7);
            applyStimulus(v, a, wd, we, be, rr, acc);
        end
        bus.req_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule
